// File: rtl/instr_stream_encoder_pkg.sv
// Shared types and the RV32I field-to-word packing used by the instruction stream encoder.
package instr_stream_encoder_pkg;

    typedef logic [31:0] raw_instr_t;

    typedef enum logic [6:0] {
        OP_LOAD     = 7'b0000011,
        OP_MISC_MEM = 7'b0001111,
        OP_IMM      = 7'b0010011,
        OP_AUIPC    = 7'b0010111,
        OP_STORE    = 7'b0100011,
        OP_REG      = 7'b0110011,
        OP_LUI      = 7'b0110111,
        OP_BRANCH   = 7'b1100011,
        OP_JALR     = 7'b1100111,
        OP_JAL      = 7'b1101111,
        OP_SYSTEM   = 7'b1110011
    } opcode_t;

    typedef enum logic [2:0] {
        TYPE_R, TYPE_I, TYPE_S, TYPE_SB, TYPE_U, TYPE_UJ, TYPE_ILLEGAL
    } instr_type_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [31:0] imm;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } decoded_instr_t;

    typedef enum logic [1:0] {
        ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE
    } enc_state_t;

    localparam raw_instr_t NOP_INSTR = 32'h0000_0013;

    function automatic instr_type_t get_instr_type(input logic [6:0] opcode);
        instr_type_t t;
        case (opcode)
            OP_REG:                                           t = TYPE_R;
            OP_LOAD, OP_MISC_MEM, OP_IMM, OP_JALR, OP_SYSTEM: t = TYPE_I;
            OP_STORE:                                         t = TYPE_S;
            OP_BRANCH:                                        t = TYPE_SB;
            OP_LUI, OP_AUIPC:                                 t = TYPE_U;
            OP_JAL:                                           t = TYPE_UJ;
            default:                                          t = TYPE_ILLEGAL;
        endcase
        return t;
    endfunction

    function automatic logic is_legal_opcode(input logic [6:0] opcode);
        return get_instr_type(opcode) != TYPE_ILLEGAL;
    endfunction

    // Branch/jump offsets are halfword aligned, so imm[0] never reaches the word.
    function automatic raw_instr_t encode_instruction(input decoded_instr_t d);
        raw_instr_t w;
        case (get_instr_type(d.opcode))
            TYPE_R:  w = {d.funct7, d.rs2, d.rs1, d.funct3, d.rd, d.opcode};
            TYPE_I:  w = {d.imm[11:0], d.rs1, d.funct3, d.rd, d.opcode};
            TYPE_S:  w = {d.imm[11:5], d.rs2, d.rs1, d.funct3, d.imm[4:0], d.opcode};
            TYPE_SB: w = {d.imm[12], d.imm[10:5], d.rs2, d.rs1, d.funct3,
                          d.imm[4:1], d.imm[11], d.opcode};
            TYPE_U:  w = {d.imm[31:12], d.rd, d.opcode};
            TYPE_UJ: w = {d.imm[20], d.imm[10:1], d.imm[11], d.imm[19:12], d.rd, d.opcode};
            default: w = NOP_INSTR;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_stream_encoder_if.sv
// Field-bundle input stream and encoded-word output stream of the instruction encoder.
interface instr_stream_encoder_if #(parameter int ADDR_W = 32);
    import instr_stream_encoder_pkg::*;

    logic              in_valid;
    logic              in_ready;
    decoded_instr_t    in_instr;
    logic              out_valid;
    logic              out_ready;
    raw_instr_t        out_instr;
    logic [ADDR_W-1:0] out_addr;

    modport master (output in_valid, in_instr, out_ready,
                    input  in_ready, out_valid, out_instr, out_addr);
    modport slave  (input  in_valid, in_instr, out_ready,
                    output in_ready, out_valid, out_instr, out_addr);
endinterface

// File: rtl/instr_stream_encoder_skid_buf.sv
// Two-entry buffer; in_ready depends only on the stored level, never on out_ready.
module instr_skid_buf #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       level
);
    logic [WIDTH-1:0] mem_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic             push_s;
    logic             pop_s;

    assign in_ready  = (count_r != 2'd2);
    assign out_valid = (count_r != 2'd0);
    assign out_data  = mem_r[rd_ptr_r];
    assign level     = count_r;
    assign push_s    = in_valid && in_ready;
    assign pop_s     = out_valid && out_ready;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r[0] <= {WIDTH{1'b0}};
            mem_r[1] <= {WIDTH{1'b0}};
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= in_data;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/instr_stream_encoder.sv
// Sequences prog_len decoded bundles into addressed RV32I words under a start/busy/done controller.
module instr_stream_encoder
    import instr_stream_encoder_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [LEN_W-1:0]   prog_len,
    instr_stream_encoder_if.slave bus,
    output logic               busy,
    output logic               done,
    output logic               err_illegal,
    output logic [CNT_W-1:0]   illegal_count
);
    localparam int BUF_W = ADDR_W + 32;

    enc_state_t        state_r, state_s;
    logic [ADDR_W-1:0] addr_r;
    logic [LEN_W-1:0]  len_r;
    logic [LEN_W-1:0]  acc_r;
    logic              err_r;
    logic [CNT_W-1:0]  ill_cnt_r;

    logic              buf_in_ready_s;
    logic              buf_out_valid_s;
    logic [BUF_W-1:0]  buf_in_data_s;
    logic [BUF_W-1:0]  buf_out_data_s;
    logic [1:0]        buf_level_s;
    logic              in_ready_s;
    logic              in_hs_s;
    logic              all_accepted_s;
    logic              drain_done_s;

    assign all_accepted_s = (acc_r == len_r);
    assign in_ready_s     = (state_r == ST_RUN) && !all_accepted_s && buf_in_ready_s;
    assign in_hs_s        = bus.in_valid && in_ready_s;
    assign buf_in_data_s  = {addr_r, encode_instruction(bus.in_instr)};
    // True when the buffer is empty after this cycle's downstream handshake.
    assign drain_done_s   = (buf_level_s == 2'd0) || ((buf_level_s == 2'd1) && bus.out_ready);

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = buf_out_valid_s;
    assign bus.out_addr   = buf_out_data_s[BUF_W-1:32];
    assign bus.out_instr  = buf_out_data_s[31:0];
    assign busy           = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    assign done           = (state_r == ST_DONE);
    assign err_illegal    = err_r;
    assign illegal_count  = ill_cnt_r;

    instr_skid_buf #(.WIDTH(BUF_W)) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_hs_s),
        .in_ready  (buf_in_ready_s),
        .in_data   (buf_in_data_s),
        .out_valid (buf_out_valid_s),
        .out_ready (bus.out_ready),
        .out_data  (buf_out_data_s),
        .level     (buf_level_s)
    );

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state: entering DONE on the last downstream handshake makes done lag it by exactly one cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (prog_len == {LEN_W{1'b0}}) state_s = ST_DONE;
                    else                           state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (all_accepted_s && drain_done_s) state_s = ST_DONE;
                else if (all_accepted_s)            state_s = ST_DRAIN;
                else                                state_s = ST_RUN;
            end
            ST_DRAIN: begin
                if (drain_done_s) state_s = ST_DONE;
                else              state_s = ST_DRAIN;
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Program bookkeeping: address/word counters and illegal-opcode tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r    <= {ADDR_W{1'b0}};
            len_r     <= {LEN_W{1'b0}};
            acc_r     <= {LEN_W{1'b0}};
            err_r     <= 1'b0;
            ill_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_IDLE) && start) begin
            addr_r    <= {base_addr[ADDR_W-1:2], 2'b00};
            len_r     <= prog_len;
            acc_r     <= {LEN_W{1'b0}};
            err_r     <= 1'b0;
            ill_cnt_r <= {CNT_W{1'b0}};
        end else if (in_hs_s) begin
            addr_r <= addr_r + ADDR_W'(4);
            acc_r  <= acc_r + LEN_W'(1);
            if (!is_legal_opcode(bus.in_instr.opcode)) begin
                err_r <= 1'b1;
                if (ill_cnt_r != {CNT_W{1'b1}}) begin
                    ill_cnt_r <= ill_cnt_r + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_instr_stream_encoder.sv
// Directed and randomized checks of instr_stream_encoder against an arithmetic reference encoder.
module tb_instr_stream_encoder;
    import instr_stream_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] prog_len;
    logic        busy, done, err_illegal;
    logic [7:0]  illegal_count;

    int n_cmp = 0;
    int n_bad = 0;

    decoded_instr_t prog[$];
    logic [31:0]    want[$];
    logic [63:0]    exp_q[$];
    logic [6:0]     legal_ops[11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                      7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};

    instr_stream_encoder_if #(.ADDR_W(32)) bus();

    instr_stream_encoder #(.ADDR_W(32), .LEN_W(16), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .prog_len(prog_len), .bus(bus), .busy(busy), .done(done),
        .err_illegal(err_illegal), .illegal_count(illegal_count)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit tb_legal(input logic [6:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Reference: place each field with shifts and masks, RV32I layout.
    function automatic logic [31:0] ref_encode(input decoded_instr_t d);
        logic [31:0] im, rd, r1, r2, f3, f7, op;
        im = d.imm; op = 32'(d.opcode);
        rd = 32'(d.rd) << 7;  f3 = 32'(d.funct3) << 12; r1 = 32'(d.rs1) << 15;
        r2 = 32'(d.rs2) << 20; f7 = 32'(d.funct7) << 25;
        case (d.opcode)
            7'h33: return f7 | r2 | r1 | f3 | rd | op;
            7'h03, 7'h0F, 7'h13, 7'h67, 7'h73: return ((im & 32'hFFF) << 20) | r1 | f3 | rd | op;
            7'h23: return (((im >> 5) & 32'h7F) << 25) | r2 | r1 | f3 | ((im & 32'h1F) << 7) | op;
            7'h63: return (((im >> 12) & 32'h1) << 31) | (((im >> 5) & 32'h3F) << 25) | r2 | r1 | f3
                          | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'h1) << 7) | op;
            7'h37, 7'h17: return (im & 32'hFFFFF000) | rd | op;
            7'h6F: return (((im >> 20) & 32'h1) << 31) | (((im >> 1) & 32'h3FF) << 21)
                          | (((im >> 11) & 32'h1) << 20) | (((im >> 12) & 32'hFF) << 12) | rd | op;
            default: return 32'h0000_0013;
        endcase
    endfunction

    function automatic decoded_instr_t mk(input logic [6:0] op, input logic [31:0] imm,
                                          input logic [2:0] f3, input logic [6:0] f7,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [4:0] rd);
        decoded_instr_t d;
        d.opcode = op; d.imm = imm; d.funct3 = f3; d.funct7 = f7;
        d.rs1 = rs1; d.rs2 = rs2; d.rd = rd;
        return d;
    endfunction

    task automatic add(input decoded_instr_t d, input logic [31:0] w);
        prog.push_back(d);
        want.push_back(w);
    endtask

    task automatic add_rand(input int n, input bit allow_illegal);
        decoded_instr_t d;
        for (int i = 0; i < n; i++) begin
            d = decoded_instr_t'({$urandom, $urandom});
            d.opcode = legal_ops[$urandom_range(0, 10)];
            if (allow_illegal && ($urandom_range(0, 7) == 0)) d.opcode = 7'h7F;
            add(d, ref_encode(d));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  64'(bus.in_ready), 64'd0);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        check({tag, "_out_instr"}, 64'(bus.out_instr), 64'd0);
        check({tag, "_out_addr"},  64'(bus.out_addr), 64'd0);
        check({tag, "_busy_done"}, 64'({busy, done}), 64'd0);
        check({tag, "_err"},       64'(err_illegal), 64'd0);
        check({tag, "_ill_cnt"},   64'(illegal_count), 64'd0);
    endtask

    // mode 0: full rate, 1: out_ready low 5 cycles, 2: random, 3: out_ready low, stop once all accepted.
    task automatic run_prog(input logic [31:0] base, input int mode, input bit mid_start);
        int          len = prog.size();
        int          idx = 0;
        int          ill = 0;
        int          last_hs = -10;
        bit          seen_done = 1'b0;
        bit          quit = 1'b0;
        bit          stalled = 1'b0;
        logic [31:0] base_al = {base[31:2], 2'b00};
        logic [63:0] held = 64'd0;
        logic [63:0] got;
        exp_q.delete();
        start = 1'b1; base_addr = base; prog_len = 16'(len);
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 600 && !seen_done && !quit; cyc++) begin
            bus.in_valid = (idx < len) && ((mode != 2) || ($urandom_range(0, 2) != 0));
            bus.in_instr = (idx < len) ? prog[idx] : '0;
            case (mode)
                1:       bus.out_ready = !((cyc >= 3) && (cyc < 8));
                2:       bus.out_ready = 1'($urandom_range(0, 1));
                3:       bus.out_ready = 1'b0;
                default: bus.out_ready = 1'b1;
            endcase
            if (mid_start && (cyc == 2)) begin
                start = 1'b1; base_addr = 32'h4000_0000; prog_len = 16'd1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            got = {bus.out_addr, bus.out_instr};
            check("in_ready", 64'(bus.in_ready), 64'((idx < len) && (exp_q.size() < 2)));
            check("out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
            if (stalled) check("stall_hold", got, held);
            if (done) begin
                seen_done = 1'b1;
                check("done_timing", 64'(cyc), 64'(last_hs + 1));
                check("done_busy", 64'(busy), 64'd0);
                check("done_left", 64'(exp_q.size() + (len - idx)), 64'd0);
            end else begin
                check("busy", 64'(busy), 64'd1);
            end
            if (bus.out_valid && bus.out_ready && (exp_q.size() != 0)) begin
                check("word", got, exp_q.pop_front());
                last_hs = cyc;
            end
            stalled = bus.out_valid && !bus.out_ready;
            held    = got;
            if (bus.in_valid && bus.in_ready && (idx < len)) begin
                exp_q.push_back({base_al + 32'(4 * idx), want[idx]});
                if (!tb_legal(prog[idx].opcode)) ill++;
                idx++;
            end
            if ((mode == 3) && (idx == len)) quit = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        if (mode != 3) begin
            check("done_seen", 64'(seen_done), 64'd1);
            check("idle_busy_done", 64'({busy, done}), 64'd0);
            check("err_illegal", 64'(err_illegal), 64'(ill != 0));
            check("illegal_count", 64'(illegal_count), 64'(ill > 255 ? 255 : ill));
        end
        prog.delete();
        want.delete();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = 32'd0; prog_len = 16'd0;
        bus.in_valid = 1'b0; bus.in_instr = '0; bus.out_ready = 1'b0;
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic program from 0x100.
        add(mk(7'h13, 32'd5, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1), 32'h0050_0093);
        add(mk(7'h33, 32'd0, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3), 32'h0020_81B3);
        add(mk(7'h23, 32'd8, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0), 32'h0020_A423);
        run_prog(32'h0000_0100, 0, 1'b0);

        // Branch/jump/upper formats, with a start pulse during RUN that must be ignored.
        add(mk(7'h63, 32'hFFFF_FFF8, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0), 32'hFE20_8CE3);
        add(mk(7'h6F, 32'd2048, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1), 32'h0010_00EF);
        add(mk(7'h37, 32'h1234_5000, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5), 32'h1234_52B7);
        add_rand(2, 1'b0);
        run_prog(32'h0000_2000, 0, 1'b1);

        // Downstream stall mid-stream.
        add_rand(6, 1'b0);
        run_prog(32'h0000_3000, 1, 1'b0);

        // Illegal opcode in the second slot.
        add(mk(7'h13, 32'd1, 3'd0, 7'd0, 5'd0, 5'd0, 5'd2), 32'h0010_0113);
        add(mk(7'h7F, 32'hFFFF_FFFF, 3'd7, 7'h7F, 5'd31, 5'd31, 5'd31), 32'h0000_0013);
        add(mk(7'h33, 32'd0, 3'd0, 7'h20, 5'd4, 5'd5, 5'd6), 32'h4052_0333);
        run_prog(32'h0000_0300, 0, 1'b0);

        // Zero-length program: done next cycle, error state cleared by the start.
        start = 1'b1; base_addr = 32'h0000_0200; prog_len = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("len0_done", 64'(done), 64'd1);
        check("len0_out_valid", 64'(bus.out_valid), 64'd0);
        check("len0_busy", 64'(busy), 64'd0);
        check("len0_err_cleared", 64'({err_illegal, illegal_count}), 64'd0);
        @(negedge clk);
        check("len0_done_pulse", 64'(done), 64'd0);
        @(posedge clk); #1;

        // Randomized traffic with occasional illegal opcodes.
        add_rand(40, 1'b1);
        run_prog($urandom, 2, 1'b0);

        // Address wrap at the top of the space.
        add_rand(2, 1'b0);
        run_prog(32'hFFFF_FFFC, 0, 1'b0);

        // Reset while draining: everything clears and done never fires.
        add(mk(7'h7F, 32'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0), 32'h0000_0013);
        add_rand(1, 1'b0);
        run_prog(32'h0000_0500, 3, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("drain_busy", 64'(busy), 64'd1);
        check("drain_err", 64'(err_illegal), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_reset_quiet", 64'({done, busy, bus.out_valid}), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
